// File: rtl/option23_line_loader_if.sv
// Character-in / display-pin-out bundle for the option23 line loader.
// master drives characters and watches the display pins; slave is the loader.
interface option23_line_loader_if;
  logic [7:0] char_data;
  logic       char_raw;
  logic       char_valid;
  logic       char_ready;
  logic       disp_reset;
  logic       disp_write;
  logic       disp_din;
  logic       busy;
  logic       frame_done;

  modport master (
    output char_data,
    output char_raw,
    output char_valid,
    input  char_ready,
    input  disp_reset,
    input  disp_write,
    input  disp_din,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  char_data,
    input  char_raw,
    input  char_valid,
    output char_ready,
    output disp_reset,
    output disp_write,
    output disp_din,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/option23_line_loader.sv
// Buffers one line of chars/raw columns, then streams it bit-serially
// into the option23 display word ring, phase-locked to its 3-bit counter.
module option23_line_loader #(
  parameter int WORD_COUNT = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  option23_line_loader_if.slave  bus
);
  localparam int CW = $clog2(WORD_COUNT + 1);
  localparam int WW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(WORD_COUNT - 1);
  localparam logic [WW-1:0] LAST_W = WW'(WORD_COUNT - 1);
  localparam logic [6:0] SPACE = 7'h40;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SEND,
    DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [6:0]    r_line [WORD_COUNT];
  logic [CW-1:0] r_count;
  logic [WW-1:0] r_w;
  logic [WW-1:0] w_w_n;
  logic [2:0]    r_p;
  logic [2:0]    w_p_n;

  logic r_ready;
  logic r_dreset;
  logic r_dwrite;
  logic r_din;
  logic r_busy;
  logic r_done;

  logic [6:0] w_word;
  logic [5:0] w_lo;
  logic       w_txt;
  logic       w_nl;
  logic       w_acc;
  logic       w_commit;
  logic       w_din_n;

  assign w_txt = !bus.char_raw;
  assign w_lo  = bus.char_data[5:0] - 6'h20;

  // Lower case folds onto upper case: a-0x40 keeps the low six bits.
  always_comb begin
    w_word = SPACE;
    w_nl   = 1'b0;
    unique case (1'b1)
      bus.char_raw:
        w_word = {1'b0, bus.char_data[5:0]};
      (w_txt && bus.char_data == 8'h0A):
        w_nl = 1'b1;
      (w_txt && bus.char_data >= 8'h20
             && bus.char_data <= 8'h5F):
        w_word = {1'b1, w_lo};
      (w_txt && bus.char_data >= 8'h61
             && bus.char_data <= 8'h7A):
        w_word = {1'b1, bus.char_data[5:0]};
      default:
        w_word = SPACE;
    endcase
  end

  assign w_acc = (r_state == IDLE) && r_ready
               && bus.char_valid;
  assign w_commit = w_acc
                 && (w_nl || r_count == LAST_C);

  always_comb begin
    w_state_n = r_state;
    w_w_n     = r_w;
    w_p_n     = r_p;
    unique case (r_state)
      IDLE: begin
        if (w_commit) w_state_n = SYNC;
      end
      SYNC: begin
        w_state_n = SEND;
        w_w_n     = '0;
        w_p_n     = '0;
      end
      SEND: begin
        w_p_n = r_p + 3'd1;
        if (r_p == 3'd7) begin
          if (r_w == LAST_W) w_state_n = DONE;
          else w_w_n = r_w + 1'b1;
        end
      end
      DONE: begin
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // Phase 7 carries a zero: the display rotates its ring on that cycle.
  assign w_din_n = (w_state_n == SEND)
                && (w_p_n != 3'd7)
                && r_line[w_w_n][w_p_n];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_p      <= '0;
      r_count  <= '0;
      r_ready  <= 1'b0;
      r_dreset <= 1'b0;
      r_dwrite <= 1'b0;
      r_din    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_w      <= w_w_n;
      r_p      <= w_p_n;
      r_ready  <= (w_state_n == IDLE);
      r_dreset <= (w_state_n == SYNC);
      r_dwrite <= (w_state_n == SEND);
      r_din    <= w_din_n;
      r_busy   <= (w_state_n == SYNC)
               || (w_state_n == SEND);
      r_done   <= (w_state_n == DONE);
      if (r_state == DONE) r_count <= '0;
      else if (w_acc && !w_nl) r_count <= r_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc && !w_nl) begin
      r_line[r_count] <= w_word;
    end else if (w_acc && w_nl) begin
      for (int i = 0; i < WORD_COUNT; i++) begin
        if (CW'(i) >= r_count) r_line[i] <= SPACE;
      end
    end
  end

  assign bus.char_ready = r_ready;
  assign bus.disp_reset = r_dreset;
  assign bus.disp_write = r_dwrite;
  assign bus.disp_din   = r_din;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_option23_line_loader.sv
// Random line traffic against a line/encoding model and a model of the
// option23 display ring driven from the loader's pins.
module tb_option23_line_loader;
  localparam int WC = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  option23_line_loader_if bus();

  option23_line_loader #(
    .WORD_COUNT(WC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Display side: free-running 3-bit counter, ring shifts on phase 7.
  logic [2:0] dcnt = 3'd0;
  logic [6:0] dsh = 7'd0;
  logic [6:0] ring [WC];

  always @(posedge clk) begin
    if (bus.disp_reset) begin
      dcnt = 3'd0;
    end else begin
      if (bus.disp_write) begin
        if (dcnt == 3'd7) begin
          for (int i = 0; i < WC - 1; i++) ring[i] = ring[i+1];
          ring[WC-1] = dsh;
        end else begin
          dsh[dcnt] = bus.disp_din;
        end
      end
      dcnt = dcnt + 3'd1;
    end
  end

  logic [6:0] mline[$];
  logic [6:0] exp_line [WC];
  logic [6:0] got_line [WC];

  function automatic void enc(input logic [7:0] d, input bit raw,
                              output logic [6:0] w, output bit nl);
    int v;
    v = int'(d);
    nl = 1'b0;
    if (raw) w = 7'(v % 64);
    else if (v == 10) begin nl = 1'b1; w = 7'h40; end
    else if (v >= 32 && v <= 95) w = 7'(64 + v - 32);
    else if (v >= 97 && v <= 122) w = 7'(64 + v - 64);
    else w = 7'h40;
  endfunction

  task automatic push(input logic [7:0] d, input bit raw);
    int n;
    n = 0;
    bus.char_data  = d;
    bus.char_raw   = raw;
    bus.char_valid = 1'b1;
    while (!bus.char_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("accept_tmo", 32'(n >= 400), 32'd0);
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic check_frame();
    int bad_wr, bad_p7, bad_rdy, rsts, rbad;
    bad_wr = 0; bad_p7 = 0; bad_rdy = 0; rsts = 0; rbad = 0;
    check("sync_rst", bus.disp_reset, 1);
    check("sync_busy", bus.busy, 1);
    check("sync_rdy", bus.char_ready, 0);
    check("sync_wr", bus.disp_write, 0);
    bus.char_data  = 8'($urandom);
    bus.char_raw   = 1'($urandom);
    bus.char_valid = 1'b1;
    for (int w = 0; w < WC; w++) begin
      for (int p = 0; p < 8; p++) begin
        @(negedge clk);
        if (!bus.disp_write || !bus.busy) bad_wr++;
        if (bus.char_ready) bad_rdy++;
        if (bus.disp_reset) rsts++;
        if (p < 7) got_line[w][p] = bus.disp_din;
        else if (bus.disp_din) bad_p7++;
      end
    end
    @(negedge clk);
    bus.char_valid = 1'b0;
    check("done_pulse", bus.frame_done, 1);
    check("done_wr", bus.disp_write, 0);
    check("done_busy", bus.busy, 0);
    check("done_rdy", bus.char_ready, 0);
    check("send_wr_gap", bad_wr, 0);
    check("send_p7_din", bad_p7, 0);
    check("send_rdy", bad_rdy, 0);
    check("send_extra_rst", rsts, 0);
    for (int w = 0; w < WC; w++) begin
      check($sformatf("word%0d", w), got_line[w], exp_line[w]);
      if (ring[w] !== exp_line[w]) rbad++;
    end
    check("disp_ring", rbad, 0);
    @(negedge clk);
    check("done_clear", bus.frame_done, 0);
    check("idle_rdy", bus.char_ready, 1);
  endtask

  task automatic put(input logic [7:0] d, input bit raw,
                     input bit do_check);
    logic [6:0] w;
    bit nl;
    bit commit;
    commit = 1'b0;
    enc(d, raw, w, nl);
    push(d, raw);
    if (nl) begin
      while (mline.size() < WC) mline.push_back(7'h40);
      commit = 1'b1;
    end else begin
      mline.push_back(w);
      commit = (mline.size() == WC);
    end
    if (commit) begin
      for (int i = 0; i < WC; i++) exp_line[i] = mline[i];
      mline.delete();
      if (do_check) check_frame();
    end
  endtask

  task automatic put_str(input string s);
    for (int i = 0; i < s.len(); i++) put(s[i], 1'b0, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < WC; i++) ring[i] = 7'd0;
    reset = 1'b1;
    bus.char_data  = 8'd0;
    bus.char_raw   = 1'b0;
    bus.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", bus.char_ready, 0);
    check("rst_drst", bus.disp_reset, 0);
    check("rst_wr", bus.disp_write, 0);
    check("rst_din", bus.disp_din, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.frame_done, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", bus.char_ready, 1);

    put_str("HI\n");
    check("hi_w0", got_line[0], 7'h68);
    check("hi_w1", got_line[1], 7'h69);
    check("hi_ring0", ring[0], 7'h68);

    put_str("ABCDEFGHIJKLMNOPQRST");
    check("full_w0", got_line[0], 7'h61);

    put(8'h61, 1'b0, 1'b1);
    put(8'h7F, 1'b0, 1'b1);
    put(8'h15, 1'b1, 1'b1);
    put(8'h0A, 1'b0, 1'b1);
    check("enc_lower", got_line[0], 7'h61);
    check("enc_del", got_line[1], 7'h40);
    check("enc_raw", got_line[2], 7'h15);

    put(8'h0A, 1'b0, 1'b1);
    check("empty_nl", got_line[0], 7'h40);

    put_str("ZAP");
    put(8'h0A, 1'b0, 1'b0);
    repeat (44) @(negedge clk);
    check("mid_wr", bus.disp_write, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_wr", bus.disp_write, 0);
    check("abort_busy", bus.busy, 0);
    reset = 1'b0;
    mline.delete();
    @(negedge clk);
    check("abort_rdy", bus.char_ready, 1);
    put_str("OK\n");
    check("ok_w0", got_line[0], 7'h6F);

    put_str("FIRST LINE\n");
    put_str("second\n");
    check("b2b_ring0", ring[0], 7'h73);

    repeat (80) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) put(8'h0A, 1'b0, 1'b1);
      else if (r == 1) put(8'($urandom), 1'b0, 1'b1);
      else if (r == 2) put(8'($urandom), 1'b1, 1'b1);
      else put(8'($urandom_range(32, 122)), 1'b0, 1'b1);
    end
    put(8'h0A, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
